// File: rtl/pipe_mux_pkg.sv
// Shared constants and select-range helper for the pipelined N-way operand mux.
package pipe_mux_pkg;
   localparam int MAX_CH    = 16;
   localparam int DEF_WIDTH = 32;
   localparam int MAX_SEL_W = $clog2(MAX_CH);

   // Callers zero-extend their select to MAX_SEL_W before the check.
   function automatic logic sel_in_range(input logic [MAX_SEL_W-1:0] sel, input int n);
      return int'(sel) < n;
   endfunction
endpackage

// File: rtl/pipe_mux_if.sv
// Handshake and data bundle between operand sources, the mux stage and the ALU.
interface pipe_mux_if
   import pipe_mux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = 4
);
   localparam int SEL_W = $clog2(N);

   logic [N*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]   in_sel;
   logic               in_valid;
   logic               in_ready;
   logic               flush;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic               sel_err;

   modport master (
      output in_data, in_sel, in_valid, flush, out_ready,
      input  in_ready, out_data, out_valid, sel_err
   );

   modport slave (
      input  in_data, in_sel, in_valid, flush, out_ready,
      output in_ready, out_data, out_valid, sel_err
   );
endinterface

// File: rtl/pipe_mux_skid.sv
// One-entry skid register; zero-latency pass of stored beat, s_rdy is registered (empty).
module pipe_mux_skid
   import pipe_mux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             s_vld,
   output logic             s_rdy,
   input  logic [WIDTH-1:0] s_dat,
   output logic             m_vld,
   input  logic             m_rdy,
   output logic [WIDTH-1:0] m_dat
);
   logic             vld_q, vld_d;
   logic [WIDTH-1:0] dat_q, dat_d;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (flush) begin
         vld_d = 1'b0;
      end else if (s_vld && !vld_q) begin
         vld_d = 1'b1;
         dat_d = s_dat;
      end else if (vld_q && m_rdy) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign s_rdy = !vld_q;
   assign m_vld = vld_q;
   assign m_dat = dat_q;
endmodule

// File: rtl/pipe_mux.sv
// Registered N-way operand select, one-cycle latency, valid/ready with flush and sticky sel_err.
// PIPE_MUX_SKID_EN adds a one-entry skid so in_ready is registered instead of following out_ready.
module pipe_mux
   import pipe_mux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   pipe_mux_if.slave bus
);
   localparam int SEL_W = $clog2(N);

   logic [WIDTH-1:0] sel_data;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             sel_err_q, sel_err_d;
   logic             accept;
   logic             out_free;
   logic             load_out;

   // Out-of-range selects match no channel and fall through to zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < N; k++) begin
         if (SEL_W'(k) == bus.in_sel) sel_data = bus.in_data[k*WIDTH +: WIDTH];
      end
   end

   assign out_free = !out_valid_q || bus.out_ready;

`ifdef PIPE_MUX_SKID_EN
   logic             skid_rdy;
   logic             skid_vld;
   logic [WIDTH-1:0] skid_dat;

   assign bus.in_ready = skid_rdy && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;

   // A beat accepted while the output is stalled parks in the skid.
   pipe_mux_skid #(.WIDTH(WIDTH)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (bus.flush),
      .s_vld (accept && !out_free),
      .s_rdy (skid_rdy),
      .s_dat (sel_data),
      .m_vld (skid_vld),
      .m_rdy (out_free),
      .m_dat (skid_dat)
   );

   assign load_out  = (skid_vld || accept) && out_free;
   assign load_data = skid_vld ? skid_dat : sel_data;
`else
   assign bus.in_ready = !bus.flush && out_free;
   assign accept       = bus.in_valid && bus.in_ready;
   assign load_out     = accept;
   assign load_data    = sel_data;
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sel_err_d   = sel_err_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
         sel_err_d   = 1'b0;
      end else begin
         if (load_out) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
         end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
         end
         if (accept && !sel_in_range(MAX_SEL_W'(bus.in_sel), N)) sel_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sel_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.sel_err   = sel_err_q;
endmodule
